// File: rtl/de0qsys_sram_arb_pkg.sv
// de0qsys_sram_arb_pkg: shared widths and owner encoding for the two-master SRAM arbiter
package de0qsys_sram_arb_pkg;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int BE_W = 4;
  typedef enum logic {M0 = 1'b0, M1 = 1'b1} owner_t;
endpackage

// File: rtl/de0qsys_sram_arb.sv
// de0qsys_sram_arb: two-master round-robin/burst SRAM arbiter with 1-cycle read return
// Define SRAM_ARB_FIXED_PRIO_EN for fixed m0 priority instead of round-robin/burst.
module de0qsys_sram_arb
  import de0qsys_sram_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] sram_address,
  output logic [BE_W-1:0]   sram_byteenable,
  output logic              sram_chipselect,
  output logic              sram_write,
  output logic [DATA_W-1:0] sram_writedata,
  output logic              sram_clken,
  input  logic [DATA_W-1:0] sram_readdata
);
  localparam logic [3:0] MB = 4'(MAX_BURST);
  owner_t     r_last, r_rd_owner, w_gnt;
  logic [3:0] r_burst;
  logic       r_rd_pend;
  logic       w_req0, w_req1, w_gnt_any, w_wr;
  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;
`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign w_gnt = w_req0 ? M0 : M1;
`else
  // burst_cnt==0 means no run in progress, so the reset owner (M1) does not hold a tie
  logic w_keep;
  assign w_keep = (r_burst != 4'd0) && (r_burst < MB);
  assign w_gnt = (w_req0 & w_req1) ? (w_keep ? r_last : owner_t'(~r_last)) : (w_req0 ? M0 : M1);
`endif
  assign w_gnt_any = ~reset & (w_req0 | w_req1);
  assign w_wr = (w_gnt == M0) ? m0_write : m1_write;
  assign m0_waitrequest = reset | (w_req0 & ~(w_gnt_any & (w_gnt == M0)));
  assign m1_waitrequest = reset | (w_req1 & ~(w_gnt_any & (w_gnt == M1)));
  assign sram_chipselect = w_gnt_any;
  assign sram_write = w_gnt_any & w_wr;
  assign sram_address = (w_gnt == M0) ? m0_address : m1_address;
  assign sram_byteenable = (w_gnt == M0) ? m0_byteenable : m1_byteenable;
  assign sram_writedata = (w_gnt == M0) ? m0_writedata : m1_writedata;
  assign sram_clken = ~reset;
  assign m0_readdata = sram_readdata;
  assign m1_readdata = sram_readdata;
  assign m0_readdatavalid = ~reset & r_rd_pend & (r_rd_owner == M0);
  assign m1_readdatavalid = ~reset & r_rd_pend & (r_rd_owner == M1);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= M1;
      r_burst <= 4'd0;
      r_rd_pend <= 1'b0;
      r_rd_owner <= M0;
    end else begin
      r_rd_pend <= w_gnt_any & ~w_wr;
      if (w_gnt_any) begin
        r_rd_owner <= w_gnt;
        r_last <= w_gnt;
        r_burst <= (w_gnt != r_last) ? 4'd1 : ((r_burst >= MB) ? MB : r_burst + 4'd1);
      end
    end
  end
endmodule

// File: doc/de0qsys_sram_arb.md
DE0QSYS_SRAM_ARB -- requirements
Module: de0qsys_sram_arb

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, meaning the maximum consecutive grants to one master while the other master is requesting (range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports m0_address / m1_address  input  13  word address.
REQ-005 SHALL have ports m0_byteenable / m1_byteenable  input  4  byte lanes.
REQ-006 SHALL have ports m0_read, m0_write, m1_read, m1_write  input  1 each  access strobes.
REQ-007 SHALL have ports m0_writedata / m1_writedata  input  32  write data.
REQ-008 SHALL have ports m0_waitrequest / m1_waitrequest  output  1  stall, combinational.
REQ-009 SHALL have ports m0_readdata / m1_readdata  output  32  read data.
REQ-010 SHALL have ports m0_readdatavalid / m1_readdatavalid  output  1  read return strobe.
REQ-011 SHALL have port sram_address  output  13  SRAM word address.
REQ-012 SHALL have port sram_byteenable  output  4  SRAM byte lanes.
REQ-013 SHALL have ports sram_chipselect / sram_write  output  1 each  SRAM access controls.
REQ-014 SHALL have port sram_writedata  output  32  SRAM write data.
REQ-015 SHALL have port sram_clken  output  1  SRAM clock enable.
REQ-016 SHALL have port sram_readdata  input  32  SRAM data; valid one cycle after the address edge.

Function
REQ-017 SHALL treat a master as requesting when read|write; read&write together SHALL be performed as a write only.
REQ-018 SHALL grant at most one master per cycle; grant is combinational from the current requests, last_owner and burst_cnt.
REQ-019 SHALL, with one requester, grant it; with both requesting, grant the master other than last_owner, unless burst_cnt < MAX_BURST, in which case last_owner keeps the grant.
REQ-020 SHALL assert mX_waitrequest = requesting & ~granted; waitrequest SHALL be 0 when not requesting.
REQ-021 SHALL drive the granted master's address/byteenable/writedata onto sram_*, with sram_chipselect=1 and sram_write=write, in the grant cycle.
REQ-022 SHALL drive sram_chipselect=0 and sram_write=0 when there is no grant; address/data are don't-care.
REQ-023 SHALL update last_owner on every grant; burst_cnt SHALL be 1 on an owner change and SHALL saturate at MAX_BURST when incrementing on a repeat grant.
REQ-024 SHALL register a granted read into rd_pend/rd_owner; next cycle mX_readdatavalid=1 for rd_owner only.
REQ-025 SHALL route sram_readdata to both mX_readdata unconditionally; validity is indicated solely by readdatavalid.
REQ-026 SHALL sustain back-to-back granted reads at one per cycle, with latency exactly 1.
REQ-027 SHALL drive sram_clken = ~reset.

Reset
REQ-028 SHALL, on reset, clear last_owner to 1 (so m0 wins the first tie), burst_cnt to 0, and rd_pend to 0.
REQ-029 SHALL force both waitrequests to 1, both readdatavalids to 0, and sram_chipselect/sram_write to 0 while reset is high.
REQ-030 SHALL discard a read pending when reset is asserted; no readdatavalid follows.

Configuration
REQ-031 SHALL, when SRAM_ARB_FIXED_PRIO_EN is defined, always grant m0 when it requests and ignore MAX_BURST and burst_cnt.
REQ-032 SHALL, when SRAM_ARB_FIXED_PRIO_EN is undefined, use the round-robin/burst scheme of REQ-019.

Structure
REQ-033 SHALL place the constants ADDR_W=13, DATA_W=32, BE_W=4 and the owner typedef (M0/M1) in package de0qsys_sram_arb_pkg.
REQ-034 SHALL be a single module without sub-modules; the readdatavalid pipe is inline.

Verification
REQ-035 SHALL verify: m0 single write 0x0010 <- 0xDEADBEEF, be=0xF -> sram_write=1 and waitrequest=0 in the same cycle; an m0 read of 0x0010 -> m0_readdatavalid=1 one cycle later with 0xDEADBEEF.
REQ-036 SHALL verify: both masters read continuously after reset, MAX_BURST=4 -> grant sequence m0 x4, m1 x4, m0 x4, with m1_waitrequest high during m0 runs.
REQ-037 SHALL verify: m1 read granted, then reset asserted next cycle -> m1_readdatavalid stays 0.
REQ-038 SHALL verify: m0 read&write both high to 0x1FFF -> a write occurs and no readdatavalid is returned.
REQ-039 SHALL verify: with SRAM_ARB_FIXED_PRIO_EN defined and both masters requesting for 10 cycles -> m0 is granted all 10 cycles and m1_waitrequest=1 throughout.
